mcs4_timing_gen: RTL and testbench
==================================

// Module: mcs4_timing_gen
// PURPOSE
//  Instruction-cycle timing generator for MCS-4.
//  - Sits directly downstream of the two-phase clock generator and consumes PHI1/PHI2.
//  - Tracks the 8 subcycles A1 A2 A3 M1 M2 X1 X2 X3 of each instruction cycle.
//  - Drives the active-low SYNC, the subcycle index and per-cycle strobes to the CPU/ROM/RAM models.
// PARAMETERS
//  CNT_W    8   width of the free-running instruction-cycle counter
//  TIMEOUT  16  max clk_i cycles between PHI2 rising edges before a clock error (check build only)
// PORTS
//  clk_i         in   1      main design clock; same clock that drives the clock generator
//  rst_i         in   1      synchronous, active-high reset
//  PHI1_i        in   1      phase 1, active low, registered in the clk_i domain
//  PHI2_i        in   1      phase 2, active low, registered in the clk_i domain
//  SYNC_o        out  1      active low; low for the whole X3 subcycle
//  SUBCYCLE_o    out  3      0=A1 1=A2 2=A3 3=M1 4=M2 5=X1 6=X2 7=X3
//  CYCLE_START_o out  1      1-clk pulse on entry to A1
//  PHI1_RISE_o   out  1      1-clk pulse, PHI1 end of phase (0->1)
//  PHI2_RISE_o   out  1      1-clk pulse, PHI2 end of phase (0->1)
//  LOCKED_o      out  1      high from the first A1 entry after reset
//  CYCLE_CNT_o   out  CNT_W  count of completed instruction cycles, wraps
//  ERR_o         out  1      sticky clock-integrity error
// BEHAVIOUR
//  - One clock, clk_i. Reset is synchronous and active-high on rst_i.
//  - No synchronisers: PHI inputs are same-domain.
//  - Edge detect: p1_q/p2_q register PHI1_i/PHI2_i.
//    - rise1 = PHI1_i & ~p1_q; rise2 = PHI2_i & ~p2_q (combinational).
//    - PHIx_RISE_o = registered rise, asserted in the clk after PHIx_i is first seen high.
//  - Subcycle state: 3-bit register advanced on rise2 only; 7 -> 0 wraps.
//    - Latency: SUBCYCLE_o changes 1 clk after PHI2_i is first seen high.
//    - The PHI2 rise ends the current subcycle.
//  - Reset values:
//    - SUBCYCLE_o=7, SYNC_o=1, CYCLE_START_o=0, PHI1_RISE_o=0, PHI2_RISE_o=0.
//    - LOCKED_o=0, CYCLE_CNT_o=0, ERR_o=0.
//    - p1_q=1, p2_q=1, so a PHI held high through reset yields no spurious edge.
//  - First rise2 after reset: state 7 -> 0 (A1).
//    - CYCLE_START_o pulses and LOCKED_o sets.
//    - CYCLE_CNT_o is not incremented.
//  - Later 7 -> 0 transitions: CYCLE_START_o pulses and CYCLE_CNT_o increments, wrapping 2^CNT_W-1 -> 0.
//  - SYNC_o is registered.
//    - Goes 0 in the same clk that SUBCYCLE_o becomes 7, provided LOCKED_o=1.
//    - Goes 1 in the same clk that SUBCYCLE_o becomes 0.
//    - The post-reset X3 never drives SYNC low.
//  - Generator at 7 clk per phase period: subcycle = 7 clk, instruction cycle = 56 clk, SYNC low 7 clk of 56.
//  - rst_i mid-cycle: all state returns to reset values on the next clk.
//    - No SYNC pulse completes.
//    - Re-lock occurs at the next rise2.
//  - rise2 when PHI1 has not risen since the previous rise2 (phase order violation):
//    - Subcycle still advances.
//    - This is flagged only in the check build.
// CONFIGURATION
//  - Macro MCS4_CLK_CHECK_EN.
//  - Defined: ERR_o sets (sticky until rst_i), 1 clk after any of the following:
//    - (a) PHI1_i==0 && PHI2_i==0 in the same clk (overlap).
//    - (b) rise2 with no rise1 since the previous rise2, after lock.
//    - (c) a clk_i watchdog counter reaches TIMEOUT with no rise2; it is cleared on each rise2 and on reset.
//  - Not defined: ERR_o tied 0; watchdog and order tracking are not synthesised.
// STRUCTURE
//  - Package mcs4_pkg:
//    - subcycle encodings SC_A1..SC_X3 (3-bit constants);
//    - SUBCYCLES=8;
//    - shared with the CPU/ROM models.
//  - Sub-module mcs4_phase_edge, instantiated twice:
//    - registered input plus rise pulse;
//    - reset value 1.
//  - Top holds the subcycle FSM, SYNC, counter and check logic.
// TESTING
//  1. Reset 3 clk, then drive from the clock generator.
//     -> The first PHI2 rise gives SUBCYCLE_o=0, CYCLE_START_o=1 for 1 clk, LOCKED_o=1, SYNC_o=1.
//  2. Run 3 full cycles.
//     -> SYNC_o low exactly 7 clk every 56 clk, aligned with SUBCYCLE_o=7.
//     -> CYCLE_CNT_o = 1, 2, 3.
//  3. CNT_W=2, run 5 cycles past lock.
//     -> CYCLE_CNT_o sequence 1, 2, 3, 0, 1.
//  4. Assert rst_i for 1 clk while SUBCYCLE_o=4.
//     -> Next clk: SUBCYCLE_o=7, SYNC_o=1, LOCKED_o=0, CYCLE_CNT_o=0.
//     -> Re-lock to A1 at the next PHI2 rise.
//  5. Check build, force PHI1_i=PHI2_i=0 for 1 clk.
//     -> ERR_o=1 on the next clk and stays 1 until rst_i.
//  6. Check build, hold PHI2_i high 20 clk with TIMEOUT=16.
//     -> ERR_o=1 at the 16th clk without a rise.
//     -> Non-check build: ERR_o stays 0 for tests 5 and 6.

Source files
------------

// File: rtl/mcs4_pkg.sv
// Shared MCS-4 definitions: subcycle encodings used by the timing generator
// and by the CPU/ROM/RAM models.
package mcs4_pkg;

  localparam int SUBCYCLES = 8;

  typedef enum logic [$clog2(SUBCYCLES)-1:0] {
    SC_A1 = 3'd0,
    SC_A2 = 3'd1,
    SC_A3 = 3'd2,
    SC_M1 = 3'd3,
    SC_M2 = 3'd4,
    SC_X1 = 3'd5,
    SC_X2 = 3'd6,
    SC_X3 = 3'd7
  } subcycle_t;

  function automatic subcycle_t next_subcycle(input subcycle_t sc);
    return (sc == SC_X3) ? SC_A1 : subcycle_t'(sc + 3'd1);
  endfunction

endpackage

// File: rtl/mcs4_phase_edge.sv
// Registers one active-low clock phase and flags its end-of-phase (0->1) edge.
module mcs4_phase_edge (
  input  logic clk,
  input  logic rst,
  input  logic phi,
  output logic rise
);

  logic phi_q;

  // Resetting to 1 means a phase held high through reset produces no edge.
  always_ff @(posedge clk) begin
    if (rst) phi_q <= 1'b1;
    else     phi_q <= phi;
  end

  assign rise = phi & ~phi_q;

endmodule

// File: rtl/mcs4_timing_gen.sv
// MCS-4 instruction-cycle timing generator: subcycle FSM, SYNC, cycle counter.
// Define MCS4_CLK_CHECK_EN to build the clock-integrity checker driving ERR_o.
module mcs4_timing_gen
  import mcs4_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             PHI1_i,
  input  logic             PHI2_i,
  output logic             SYNC_o,
  output logic [2:0]       SUBCYCLE_o,
  output logic             CYCLE_START_o,
  output logic             PHI1_RISE_o,
  output logic             PHI2_RISE_o,
  output logic             LOCKED_o,
  output logic [CNT_W-1:0] CYCLE_CNT_o,
  output logic             ERR_o
);

  logic rise1;
  logic rise2;

  mcs4_phase_edge u_phi1_edge (
    .clk  (clk_i),
    .rst  (rst_i),
    .phi  (PHI1_i),
    .rise (rise1)
  );

  mcs4_phase_edge u_phi2_edge (
    .clk  (clk_i),
    .rst  (rst_i),
    .phi  (PHI2_i),
    .rise (rise2)
  );

  subcycle_t        subcycle;
  logic             sync;
  logic             cycle_start;
  logic             phi1_rise;
  logic             phi2_rise;
  logic             locked;
  logic [CNT_W-1:0] cycle_cnt;

  // The PHI2 rise closes the current subcycle. Starting from X3 lets the
  // first rise land on A1; that first X3 is never announced on SYNC and the
  // cycle it closes is not counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      subcycle    <= SC_X3;
      sync        <= 1'b1;
      cycle_start <= 1'b0;
      phi1_rise   <= 1'b0;
      phi2_rise   <= 1'b0;
      locked      <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      phi1_rise   <= rise1;
      phi2_rise   <= rise2;
      cycle_start <= 1'b0;
      if (rise2) begin
        subcycle <= next_subcycle(subcycle);
        case (subcycle)
          SC_X2: begin
            if (locked) sync <= 1'b0;
          end
          SC_X3: begin
            sync        <= 1'b1;
            cycle_start <= 1'b1;
            locked      <= 1'b1;
            if (locked) cycle_cnt <= cycle_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign SUBCYCLE_o    = subcycle;
  assign SYNC_o        = sync;
  assign CYCLE_START_o = cycle_start;
  assign PHI1_RISE_o   = phi1_rise;
  assign PHI2_RISE_o   = phi2_rise;
  assign LOCKED_o      = locked;
  assign CYCLE_CNT_o   = cycle_cnt;

`ifdef MCS4_CLK_CHECK_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] watchdog;
  logic            seen1;
  logic            err;
  logic            overlap;
  logic            order_err;
  logic            wd_expire;

  assign overlap   = ~PHI1_i & ~PHI2_i;
  assign order_err = rise2 & locked & ~(seen1 | rise1);
  assign wd_expire = ~rise2 & (watchdog == WD_W'(TIMEOUT - 1));

  // Watchdog saturates at TIMEOUT; seen1 remembers a PHI1 rise within the
  // current PHI2 period so that a missing PHI1 is caught at the next PHI2 rise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      watchdog <= '0;
      seen1    <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (rise2) begin
        watchdog <= '0;
        seen1    <= 1'b0;
      end else begin
        seen1 <= seen1 | rise1;
        if (watchdog != WD_W'(TIMEOUT)) watchdog <= watchdog + 1'b1;
      end
      if (overlap || order_err || wd_expire) err <= 1'b1;
    end
  end

  assign ERR_o = err;
`else
  assign ERR_o = 1'b0;
`endif

endmodule

// File: tb/tb_mcs4_timing_gen.sv
// Self-checking bench for mcs4_timing_gen: vector table, directed sequences
// and randomized phase streams against an event-counting reference model.
module tb_mcs4_timing_gen;

  localparam int TIMEOUT = 16;
`ifdef MCS4_CLK_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       p1;
  logic       p2;

  logic       sync_n, cstart, r1, r2, locked, err;
  logic [2:0] sub;
  logic [7:0] cnt;
  logic       sync_n2, cstart2, r1_2, r2_2, locked2, err2;
  logic [2:0] sub2;
  logic [1:0] cnt2;

  mcs4_timing_gen #(.CNT_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .PHI1_i(p1), .PHI2_i(p2),
    .SYNC_o(sync_n), .SUBCYCLE_o(sub), .CYCLE_START_o(cstart),
    .PHI1_RISE_o(r1), .PHI2_RISE_o(r2), .LOCKED_o(locked),
    .CYCLE_CNT_o(cnt), .ERR_o(err)
  );

  mcs4_timing_gen #(.CNT_W(2), .TIMEOUT(TIMEOUT)) dut_w2 (
    .clk_i(clk), .rst_i(rst), .PHI1_i(p1), .PHI2_i(p2),
    .SYNC_o(sync_n2), .SUBCYCLE_o(sub2), .CYCLE_START_o(cstart2),
    .PHI1_RISE_o(r1_2), .PHI2_RISE_o(r2_2), .LOCKED_o(locked2),
    .CYCLE_CNT_o(cnt2), .ERR_o(err2)
  );

  always #5 clk = ~clk;

  // Reference model state: everything follows from how many PHI2 rises
  // have been seen since reset.
  int rises2    = 0;
  bit prev1     = 1'b1;
  bit prev2     = 1'b1;
  bit m_r1      = 1'b0;
  bit m_r2      = 1'b0;
  bit m_start   = 1'b0;
  int rise1_cnt = 0;
  int idle      = 0;
  bit m_err     = 1'b0;

  int total = 0;
  int bad   = 0;
  int pos   = 0;

  typedef struct {
    bit rst; bit p1; bit p2;
    int sub; bit sync; bit start; bit lock; bit r1; bit r2;
  } vec_t;

  vec_t tbl[10];

  task automatic modelEdge(input bit r, input bit a, input bit b);
    bit rise1, rise2;
    if (r) begin
      rises2 = 0; prev1 = 1'b1; prev2 = 1'b1;
      m_r1 = 1'b0; m_r2 = 1'b0; m_start = 1'b0;
      rise1_cnt = 0; idle = 0; m_err = 1'b0;
    end else begin
      rise1 = a && !prev1;
      rise2 = b && !prev2;
      if (rise1) rise1_cnt++;
      if (!a && !b) m_err = 1'b1;
      if (rise2 && rises2 > 0 && rise1_cnt == 0) m_err = 1'b1;
      if (rise2) begin
        rises2++;
        idle = 0;
        rise1_cnt = 0;
      end else begin
        idle++;
        if (idle == TIMEOUT) m_err = 1'b1;
      end
      m_r1 = rise1;
      m_r2 = rise2;
      m_start = rise2 && (rises2 % 8 == 1);
      prev1 = a;
      prev2 = b;
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    int sub_e, cyc_e;
    bit lock_e, sync_e, err_e;
    sub_e  = (7 + rises2) % 8;
    lock_e = rises2 > 0;
    cyc_e  = lock_e ? (rises2 - 1) / 8 : 0;
    sync_e = !(sub_e == 7 && rises2 >= 8);
    err_e  = CHECK && m_err;
    checkOutput("subcycle",    int'(sub),    sub_e);
    checkOutput("sync",        int'(sync_n), int'(sync_e));
    checkOutput("cycle_start", int'(cstart), int'(m_start));
    checkOutput("phi1_rise",   int'(r1),     int'(m_r1));
    checkOutput("phi2_rise",   int'(r2),     int'(m_r2));
    checkOutput("locked",      int'(locked), int'(lock_e));
    checkOutput("cycle_cnt",   int'(cnt),    cyc_e % 256);
    checkOutput("err",         int'(err),    int'(err_e));
    checkOutput("w2_subcycle", int'(sub2),    sub_e);
    checkOutput("w2_sync",     int'(sync_n2), int'(sync_e));
    checkOutput("w2_start",    int'(cstart2), int'(m_start));
    checkOutput("w2_phi1",     int'(r1_2),    int'(m_r1));
    checkOutput("w2_phi2",     int'(r2_2),    int'(m_r2));
    checkOutput("w2_locked",   int'(locked2), int'(lock_e));
    checkOutput("w2_cnt",      int'(cnt2),    cyc_e % 4);
    checkOutput("w2_err",      int'(err2),    int'(err_e));
  endtask

  task automatic applyStimulus(input bit r, input bit a, input bit b);
    rst = r; p1 = a; p2 = b;
    @(posedge clk);
    modelEdge(r, a, b);
    #1;
    checkAll();
  endtask

  // Clock generator model: 7 clk per phase period, PHI1 low at 0-1,
  // PHI2 low at 3-4, never overlapping.
  task automatic genStep(input bit r);
    applyStimulus(r, (pos != 0 && pos != 1), (pos != 3 && pos != 4));
    pos = (pos + 1) % 7;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int cnt_q[$];
    int cnt2_q[$];
    int sync_low;
    bit seen;

    tbl[0] = '{1,1,1, 7,1,0,0,0,0};
    tbl[1] = '{1,1,1, 7,1,0,0,0,0};
    tbl[2] = '{1,1,1, 7,1,0,0,0,0};
    tbl[3] = '{0,1,1, 7,1,0,0,0,0};
    tbl[4] = '{0,0,1, 7,1,0,0,0,0};
    tbl[5] = '{0,1,1, 7,1,0,0,1,0};
    tbl[6] = '{0,1,0, 7,1,0,0,0,0};
    tbl[7] = '{0,1,1, 0,1,1,1,0,1};
    tbl[8] = '{0,1,1, 0,1,0,1,0,0};
    tbl[9] = '{0,0,1, 0,1,0,1,0,0};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].p1, tbl[i].p2);
      checkOutput("tbl_sub",    int'(sub),    tbl[i].sub);
      checkOutput("tbl_sync",   int'(sync_n), int'(tbl[i].sync));
      checkOutput("tbl_start",  int'(cstart), int'(tbl[i].start));
      checkOutput("tbl_locked", int'(locked), int'(tbl[i].lock));
      checkOutput("tbl_phi1",   int'(r1),     int'(tbl[i].r1));
      checkOutput("tbl_phi2",   int'(r2),     int'(tbl[i].r2));
      checkOutput("tbl_err",    int'(err),    0);
    end

    // Reset, then lock on the first PHI2 rise from the generator.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    pos = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      genStep(1'b0);
      seen = cstart;
    end
    checkOutput("lock_seen",   int'(seen),   1);
    checkOutput("lock_sub",    int'(sub),    0);
    checkOutput("lock_locked", int'(locked), 1);
    checkOutput("lock_sync",   int'(sync_n), 1);

    // Five full instruction cycles: SYNC low 7 of every 56 clk, counters step.
    sync_low = 0;
    for (int i = 0; i < 5 * 56; i++) begin
      genStep(1'b0);
      if (!sync_n) begin
        sync_low++;
        checkOutput("sync_in_x3", int'(sub), 7);
      end
      if (cstart) begin
        cnt_q.push_back(int'(cnt));
        cnt2_q.push_back(int'(cnt2));
      end
    end
    checkOutput("sync_low_clks", sync_low, 35);
    checkOutput("start_count",   cnt_q.size(), 5);
    for (int i = 0; i < 5 && i < cnt_q.size(); i++) begin
      checkOutput("cnt_seq",    cnt_q[i],  i + 1);
      checkOutput("cnt_w2_seq", cnt2_q[i], (i + 1) % 4);
    end

    // Reset mid-cycle at M2, then re-lock at the next PHI2 rise.
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      genStep(1'b0);
      seen = (sub == 3'd4);
    end
    checkOutput("reach_m2", int'(seen), 1);
    genStep(1'b1);
    checkOutput("rst_sub",    int'(sub),    7);
    checkOutput("rst_sync",   int'(sync_n), 1);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_cnt",    int'(cnt),    0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      genStep(1'b0);
      seen = locked;
    end
    checkOutput("relock_seen",  int'(seen),   1);
    checkOutput("relock_sub",   int'(sub),    0);
    checkOutput("relock_start", int'(cstart), 1);

    // Phase overlap for one clk: sticky error in the check build.
    for (int i = 0; i < 10; i++) genStep(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("overlap_err", int'(err), int'(CHECK));
    for (int i = 0; i < 30; i++) genStep(1'b0);
    checkOutput("overlap_sticky", int'(err), int'(CHECK));
    genStep(1'b1);
    checkOutput("overlap_cleared", int'(err), 0);

    // PHI2 held high: watchdog fires at the 16th clk without a rise.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      if (i == 14) checkOutput("wd_before", int'(err), 0);
      if (i == 15) checkOutput("wd_fire",   int'(err), int'(CHECK));
      if (i == 19) checkOutput("wd_hold",   int'(err), int'(CHECK));
    end

    // Randomized streams: mostly clean generator, with glitches and resets.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    pos = 0;
    for (int i = 0; i < 3000; i++) begin
      int dice;
      dice = int'($urandom_range(0, 199));
      if (dice == 0) genStep(1'b1);
      else if (dice < 9) applyStimulus(1'b0, 1'($urandom), 1'($urandom));
      else genStep(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
